uart_tx_ctrl: RTL and testbench

//   Upstream control and datapath stage of the UART transmitter. Accepts a parallel byte,

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_tx_serializer.sv | 51 +++++
 rtl/uart_tx_ctrl.sv | 103 ++++++++++
 tb/tb_uart_tx_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: output-mux select codes and the
// transmit-control FSM state type. The downstream output-mux stage uses
// the same select constants.
package uart_pkg;

  localparam logic [1:0] SEL_START = 2'b00;
  localparam logic [1:0] SEL_STOP  = 2'b01;
  localparam logic [1:0] SEL_DATA  = 2'b10;
  localparam logic [1:0] SEL_PAR   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Output-mux select presented while the FSM sits in a given state.
  // IDLE and STOP share the stop-level select so the line rests high.
  function automatic logic [1:0] sel_for_state(input tx_state_t st);
    logic [1:0] sel;
    sel = SEL_STOP;
    case (st)
      ST_START:  sel = SEL_START;
      ST_DATA:   sel = SEL_DATA;
      ST_PARITY: sel = SEL_PAR;
      default:   sel = SEL_STOP;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shifter for the UART transmitter: loads a word, shifts it out
// LSB first one bit per enabled cycle and flags the last bit of the word.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  cnt_clr,
  input  logic                  shift_en,
  output logic                  ser_bit,
  output logic                  done
);

  localparam int unsigned CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_q;
  logic [CW-1:0]         count_q;

  // Word register and bit counter; the counter returns to zero on the
  // final bit so it never wraps inside a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (load) begin
      shift_q <= load_data;
      count_q <= '0;
    end else begin
      if (shift_en) begin
        shift_q <= {1'b0, shift_q[DATA_WIDTH-1:1]};
      end
      if (cnt_clr || done) begin
        count_q <= '0;
      end else if (shift_en) begin
        count_q <= count_q + CW'(1);
      end
    end
  end

  // Current bit comes straight from the register; done marks the last bit.
  always_comb begin
    ser_bit = shift_q[0];
    done    = shift_en && (count_q == LAST);
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit control stage: accepts a byte, sequences
// START -> DATA (LSB first) -> [PARITY] -> STOP and drives the select,
// serial data and parity inputs of the downstream output-mux stage.
// One frame bit per clock; every output is a register.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            Mux_Sel,
  output logic                  Ser_Data,
  output logic                  Parity,
  output logic                  Busy
);

  tx_state_t state, next_state;
  logic      accept;
  logic      cnt_clr;
  logic      shift_en;
  logic      ser_bit;
  logic      ser_done;
  logic      par_en_q;

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_serializer (
    .clk      (CLK),
    .rst      (RST),
    .load     (accept),
    .load_data(P_DATA),
    .cnt_clr  (cnt_clr),
    .shift_en (shift_en),
    .ser_bit  (ser_bit),
    .done     (ser_done)
  );

  // State register; select and busy are registered from the next state so
  // they change on the same edge as the state itself.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      Mux_Sel <= SEL_STOP;
      Busy    <= 1'b0;
    end else begin
      state   <= next_state;
      Mux_Sel <= sel_for_state(next_state);
      Busy    <= (next_state != ST_IDLE);
    end
  end

  // Frame options captured with the payload so later input changes cannot
  // affect the frame in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Parity   <= 1'b0;
      par_en_q <= 1'b0;
    end else if (accept) begin
      Parity   <= (^P_DATA) ^ PAR_TYP;
      par_en_q <= PAR_EN;
    end
  end

  // Next-state and serializer control; requests are only seen in IDLE.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    cnt_clr    = 1'b0;
    shift_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Data_Valid) begin
          accept     = 1'b1;
          next_state = ST_START;
        end
      end
      ST_START: begin
        cnt_clr    = 1'b1;
        next_state = ST_DATA;
      end
      ST_DATA: begin
        shift_en = 1'b1;
        if (ser_done) begin
          next_state = par_en_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: next_state = ST_STOP;
      ST_STOP:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Serial data is the serializer's register bit, valid during DATA.
  always_comb begin
    Ser_Data = ser_bit;
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl with a model of the downstream
// output-mux stage driving tx_out.
module tb_uart_tx_ctrl;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic [1:0] mux_sel;
  logic       ser_data;
  logic       parity;
  logic       busy;
  logic       tx_out;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned busy_cnt;
  logic        prev_line;

  typedef struct {
    logic [7:0]  data;
    logic        pe;
    logic        pt;
    logic        exp_par;
    int unsigned exp_len;
    int          inj;
  } vec_t;

  vec_t vecs[8];

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK       (clk),
    .RST       (rst),
    .P_DATA    (p_data),
    .Data_Valid(data_valid),
    .PAR_EN    (par_en),
    .PAR_TYP   (par_typ),
    .Mux_Sel   (mux_sel),
    .Ser_Data  (ser_data),
    .Parity    (parity),
    .Busy      (busy)
  );

  always #5 clk = ~clk;

  // Downstream output-mux stage: registers the selected bit; idle high.
  always_ff @(posedge clk) begin
    if (rst) tx_out <= 1'b1;
    else begin
      case (mux_sel)
        2'b00:   tx_out <= 1'b0;
        2'b01:   tx_out <= 1'b1;
        2'b10:   tx_out <= ser_data;
        default: tx_out <= parity;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s %s: got %0h expected %0h", tag, what, act, exp);
  endtask

  // Check one cycle's outputs, then advance to just after the next edge.
  task automatic cyc(input string tag, input logic [1:0] esel,
                     input logic ebusy, input logic ebit);
    check(tag, "mux_sel", 32'(mux_sel), 32'(esel));
    check(tag, "busy", 32'(busy), 32'(ebusy));
    if (esel == SEL_DATA) check(tag, "ser_data", 32'(ser_data), 32'(ebit));
    if (esel == SEL_PAR)  check(tag, "parity", 32'(parity), 32'(ebit));
    check(tag, "tx_out", 32'(tx_out), 32'(prev_line));
    if (busy === 1'b1) busy_cnt++;
    prev_line = (esel == SEL_START) ? 1'b0 : (esel == SEL_STOP) ? 1'b1 : ebit;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input string tag, input vec_t v);
    busy_cnt   = 0;
    p_data     = v.data;
    par_en     = v.pe;
    par_typ    = v.pt;
    data_valid = 1'b1;
    cyc({tag, " accept"}, SEL_STOP, 1'b0, 1'b0);
    data_valid = 1'b0;
    p_data     = ~v.data;
    par_typ    = ~v.pt;
    cyc({tag, " start"}, SEL_START, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == v.inj) begin
        data_valid = 1'b1;
        p_data     = 8'hFF;
        par_en     = ~v.pe;
      end
      cyc($sformatf("%s d%0d", tag, i), SEL_DATA, 1'b1, v.data[i]);
      data_valid = 1'b0;
    end
    if (v.pe) cyc({tag, " par"}, SEL_PAR, 1'b1, v.exp_par);
    cyc({tag, " stop"}, SEL_STOP, 1'b1, 1'b0);
    cyc({tag, " idle0"}, SEL_STOP, 1'b0, 1'b0);
    cyc({tag, " idle1"}, SEL_STOP, 1'b0, 1'b0);
    check(tag, "busy_len", busy_cnt, v.exp_len);
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, pe: 1'b0, pt: 1'b0, exp_par: 1'b0, exp_len: 10, inj: -1};
    vecs[1] = '{data: 8'hA5, pe: 1'b1, pt: 1'b0, exp_par: 1'b0, exp_len: 11, inj: -1};
    vecs[2] = '{data: 8'hA5, pe: 1'b1, pt: 1'b1, exp_par: 1'b1, exp_len: 11, inj: -1};
    vecs[3] = '{data: 8'h3C, pe: 1'b1, pt: 1'b1, exp_par: 1'b1, exp_len: 11, inj: -1};
    vecs[4] = '{data: 8'h01, pe: 1'b1, pt: 1'b0, exp_par: 1'b1, exp_len: 11, inj: -1};
    vecs[5] = '{data: 8'hFE, pe: 1'b1, pt: 1'b1, exp_par: 1'b0, exp_len: 11, inj: -1};
    vecs[6] = '{data: 8'hA5, pe: 1'b0, pt: 1'b0, exp_par: 1'b0, exp_len: 10, inj: 3};
    vecs[7] = '{data: 8'h12, pe: 1'b1, pt: 1'b0, exp_par: 1'b0, exp_len: 11, inj: 5};

    rst        = 1'b1;
    p_data     = 8'h00;
    data_valid = 1'b0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", "mux_sel", 32'(mux_sel), 32'(SEL_STOP));
    check("reset", "busy", 32'(busy), 32'd0);
    check("reset", "ser_data", 32'(ser_data), 32'd0);
    check("reset", "parity", 32'(parity), 32'd0);
    check("reset", "tx_out", 32'(tx_out), 32'd1);
    rst       = 1'b0;
    prev_line = 1'b1;
    cyc("post_reset", SEL_STOP, 1'b0, 1'b0);

    for (int k = 0; k < 8; k++) run_frame($sformatf("vec%0d", k), vecs[k]);

    // Reset during the 4th data bit aborts the frame at once.
    p_data     = 8'hA5;
    par_en     = 1'b1;
    par_typ    = 1'b1;
    data_valid = 1'b1;
    cyc("abort accept", SEL_STOP, 1'b0, 1'b0);
    data_valid = 1'b0;
    cyc("abort start", SEL_START, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc($sformatf("abort d%0d", i), SEL_DATA, 1'b1, p_data[i]);
    rst = 1'b1;
    cyc("abort d3", SEL_DATA, 1'b1, 1'b0);
    rst = 1'b0;
    check("abort", "ser_data", 32'(ser_data), 32'd0);
    check("abort", "parity", 32'(parity), 32'd0);
    prev_line = 1'b1;
    cyc("abort idle", SEL_STOP, 1'b0, 1'b0);
    run_frame("after_abort", '{data: 8'h5A, pe: 1'b1, pt: 1'b0, exp_par: 1'b0,
                               exp_len: 11, inj: -1});

    // Data_Valid held high: back-to-back frames with one IDLE cycle between.
    p_data     = 8'h00;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    data_valid = 1'b1;
    cyc("b2b accept0", SEL_STOP, 1'b0, 1'b0);
    p_data = 8'hFF;
    cyc("b2b start0", SEL_START, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cyc($sformatf("b2b f0 d%0d", i), SEL_DATA, 1'b1, 1'b0);
    cyc("b2b stop0", SEL_STOP, 1'b1, 1'b0);
    cyc("b2b gap", SEL_STOP, 1'b0, 1'b0);
    p_data = 8'h00;
    cyc("b2b start1", SEL_START, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cyc($sformatf("b2b f1 d%0d", i), SEL_DATA, 1'b1, 1'b1);
    cyc("b2b stop1", SEL_STOP, 1'b1, 1'b0);
    data_valid = 1'b0;
    cyc("b2b idle0", SEL_STOP, 1'b0, 1'b0);
    cyc("b2b idle1", SEL_STOP, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
